// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
//   Shared definitions for the UART transmitter:
//     - tx_state_e    : frame sequencing states
//     - MAX_DATA_BITS : widest data field the transmitter supports
//     - frame_parity  : parity bit over the low nbits of a data word
// ---------------------------------------------------------------------------
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam int unsigned MAX_DATA_BITS = 9;

   // XOR of data[nbits-1:0]; starting from 'odd' inverts the result for odd parity.
   function automatic logic frame_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input int unsigned              nbits,
                                         input logic                     odd);
      logic p;
      p = odd;
      for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
         if (i < nbits) begin
            p = p ^ data[i];
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_tx_rise_detect.sv
// ---------------------------------------------------------------------------
// uart_tx_rise_detect
//   Registers a clk-synchronous level (the divider output) and flags its
//   rising edge as a pulse exactly one clk wide. Usable by any consumer of the
//   clock divider that needs a bit-period tick.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset (clears the history flop)
//   sig_in in   level to watch, synchronous to clk
//   tick   out  high for one clk when sig_in is 1 and was 0 on the last edge
// ---------------------------------------------------------------------------
module uart_tx_rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig_in,
   output logic tick
);

   logic sig_q;
   logic sig_d;

   always_comb begin
      sig_d = sig_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign tick = sig_in & ~sig_q;

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//   Serial transmitter paced by the divided clock. Every rising edge of
//   div_clk becomes a one-clk tick, and each tick advances the frame by one
//   bit: start (0), data LSB first, optional parity, then stop bit(s) (1).
//   A valid/ready handshake accepts one data word per frame.
//
// Parameters:
//   DATA_BITS  data bits per frame (5..9)
//   STOP_BITS  stop bits per frame (1 or 2)
//   PARITY_EN  1 = insert a parity bit after the data
//   PARITY_ODD 1 = odd parity, 0 = even (ignored when PARITY_EN = 0)
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   div_clk   in   divided clock, synchronous to clk
//   tx_data   in   word to send, latched on transfer
//   tx_valid  in   tx_data valid
//   tx_ready  out  high while idle; transfer = tx_valid & tx_ready
//   tx        out  registered serial line, idle high
//   busy      out  frame pending or in progress
// ---------------------------------------------------------------------------
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 div_clk,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy
);

   localparam int unsigned    CNT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   tx_state_e            state_q,  state_d;
   logic [DATA_BITS-1:0] shreg_q,  shreg_d;
   logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
   logic                 parity_q, parity_d;
   logic                 tx_q,     tx_d;

   logic                     tick;
   logic [MAX_DATA_BITS-1:0] data_ext;

   uart_tx_rise_detect u_rise_detect (
      .clk    (clk),
      .reset  (reset),
      .sig_in (div_clk),
      .tick   (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      parity_d = parity_q;
      tx_d     = tx_q;

      data_ext                  = '0;
      data_ext[DATA_BITS-1:0]   = tx_data;

      case (state_q)
         IDLE: begin
            // Parity is captured with the word, since the shift register
            // consumes the data as the frame goes out.
            if (tx_valid) begin
               shreg_d  = tx_data;
               parity_d = frame_parity(data_ext, DATA_BITS, PARITY_ODD != 0);
               state_d  = ARM;
            end
         end

         // ARM is entered on the edge that ends the transfer cycle, so a tick
         // coinciding with the transfer is never seen here.
         ARM: begin
            if (tick) begin
               tx_d    = 1'b0;
               state_d = START;
            end
         end

         START: begin
            if (tick) begin
               tx_d     = shreg_q[0];
               bitcnt_d = '0;
               state_d  = DATA;
            end
         end

         DATA: begin
            if (tick) begin
               if (bitcnt_q == LAST_BIT) begin
                  if (PARITY_EN != 0) begin
                     tx_d    = parity_q;
                     state_d = PARITY;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = (STOP_BITS == 2) ? STOP : IDLE;
                  end
               end else begin
                  shreg_d  = shreg_q >> 1;
                  tx_d     = shreg_q[1];
                  bitcnt_d = bitcnt_q + 1'b1;
               end
            end
         end

         PARITY: begin
            if (tick) begin
               tx_d    = 1'b1;
               state_d = (STOP_BITS == 2) ? STOP : IDLE;
            end
         end

         // The line is already high; leaving on the next tick makes the final
         // stop bit last one full interval before a new start can be driven.
         STOP: begin
            if (tick) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign tx       = tx_q;
   assign tx_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//   Four transmitters share clk/reset/div_clk:
//     0: 8N1   1: 8 even parity 1 stop   2: 8 odd parity 1 stop   3: 8N2
//   div_clk is a square wave of 6 clk, so one tick every 6 clk.
//   Expected frames are queued when a word is offered; per-instance monitors
//   pop them when a start bit appears and check every clk of every bit.
// ---------------------------------------------------------------------------
module tb_uart_tx;

   typedef struct packed {
      logic [11:0] bits;   // bit i = i-th bit on the line
      logic [3:0]  n;      // number of frame bits
      logic        b2b;    // must start immediately after the previous frame
   } frame_t;

   typedef struct {
      int unsigned idx;
      logic [7:0]  data;
      logic [11:0] bits;
      int unsigned n;
   } vec_t;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic       div_clk = 1'b0;
   int         div_cnt = 5;

   logic [7:0] data_r  [4] = '{default: 8'h00};
   logic       valid_r [4] = '{default: 1'b0};
   logic       tx_w    [4];
   logic       ready_w [4];
   logic       busy_w  [4];

   frame_t     exp_q    [4][$];
   logic       in_frame [4] = '{default: 1'b0};
   int         cur_bit  [4] = '{default: -1};
   int         gap      [4] = '{default: 0};

   int errors = 0;
   int checks = 0;

   vec_t vecs [11];

   always #5 clk = ~clk;

   // Registered-style square wave: changes only at negedge, 3 high / 3 low.
   initial begin
      forever begin
         @(negedge clk);
         div_cnt = (div_cnt == 5) ? 0 : div_cnt + 1;
         div_clk = (div_cnt < 3);
      end
   end

   uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
      .clk(clk), .reset(reset), .div_clk(div_clk), .tx_data(data_r[0]), .tx_valid(valid_r[0]),
      .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
   uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
      .clk(clk), .reset(reset), .div_clk(div_clk), .tx_data(data_r[1]), .tx_valid(valid_r[1]),
      .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
   uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
      .clk(clk), .reset(reset), .div_clk(div_clk), .tx_data(data_r[2]), .tx_valid(valid_r[2]),
      .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
   uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0)) u_dut3 (
      .clk(clk), .reset(reset), .div_clk(div_clk), .tx_data(data_r[3]), .tx_valid(valid_r[3]),
      .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic tick_sample();
      @(negedge clk);
      #1;
   endtask

   // Watches one instance's line; a low sample while out of reset is a start bit.
   task automatic monitor(input int idx);
      frame_t     f;
      logic [5:0] smp;
      int         hs_bad;
      logic       aborted;
      forever begin
         tick_sample();
         if (reset || tx_w[idx] !== 1'b0) begin
            gap[idx]++;
            continue;
         end
         in_frame[idx] = 1'b1;
         chk($sformatf("start_phase_i%0d", idx), div_cnt, 1);
         if (exp_q[idx].size() == 0) begin
            chk($sformatf("unexpected_frame_i%0d", idx), 1, 0);
            f = '{bits: 12'h000, n: 4'd10, b2b: 1'b0};
         end else begin
            f = exp_q[idx].pop_front();
         end
         if (f.b2b) chk($sformatf("b2b_gap_i%0d", idx), gap[idx], 0);
         aborted = 1'b0;
         for (int b = 0; b < int'(f.n) && !aborted; b++) begin
            cur_bit[idx] = b;
            smp    = '0;
            hs_bad = 0;
            for (int s = 0; s < 6; s++) begin
               if (b != 0 || s != 0) tick_sample();
               if (reset) begin
                  aborted = 1'b1;
                  break;
               end
               smp[s] = tx_w[idx];
               if (b < int'(f.n) - 1) begin
                  if (!(busy_w[idx] == 1'b1 && ready_w[idx] == 1'b0)) hs_bad++;
               end else if (s == 0) begin
                  if (!(busy_w[idx] == 1'b0 && ready_w[idx] == 1'b1)) hs_bad++;
               end
            end
            if (!aborted) begin
               chk($sformatf("line_i%0d_bit%0d", idx, b), int'(smp), f.bits[b] ? 'h3F : 'h00);
               chk($sformatf("handshake_i%0d_bit%0d", idx, b), hs_bad, 0);
            end
         end
         in_frame[idx] = 1'b0;
         cur_bit[idx]  = -1;
         gap[idx]      = 0;
      end
   endtask

   initial monitor(0);
   initial monitor(1);
   initial monitor(2);
   initial monitor(3);

   task automatic wait_ready(input int idx);
      int t;
      t = 0;
      while (!ready_w[idx] && t < 200) begin
         tick_sample();
         t++;
      end
      chk($sformatf("ready_wait_i%0d", idx), int'(ready_w[idx]), 1);
   endtask

   task automatic send(input int idx, input logic [7:0] d, input logic [11:0] bits,
                       input int n);
      tick_sample();
      wait_ready(idx);
      data_r[idx]  = d;
      valid_r[idx] = 1'b1;
      exp_q[idx].push_back('{bits: bits, n: 4'(n), b2b: 1'b0});
      tick_sample();
      valid_r[idx] = 1'b0;
   endtask

   task automatic wait_idle(input int idx);
      int t;
      t = 0;
      while ((exp_q[idx].size() != 0 || in_frame[idx] || !ready_w[idx]) && t < 400) begin
         tick_sample();
         t++;
      end
      chk($sformatf("drain_i%0d", idx), (t < 400) ? 1 : 0, 1);
   endtask

   // Offer a word at a chosen div phase and measure clk samples until start bit.
   task automatic send_phase(input int idx, input logic [7:0] d, input logic [11:0] bits,
                             input int n, input int phase, input int exp_lat);
      int t;
      int lat;
      t = 0;
      tick_sample();
      while (div_cnt != phase && t < 12) begin
         tick_sample();
         t++;
      end
      data_r[idx]  = d;
      valid_r[idx] = 1'b1;
      exp_q[idx].push_back('{bits: bits, n: 4'(n), b2b: 1'b0});
      lat = 0;
      do begin
         tick_sample();
         lat++;
         if (lat == 1) valid_r[idx] = 1'b0;
      end while (tx_w[idx] && lat < 20);
      chk($sformatf("latency_i%0d_phase%0d", idx, phase), lat, exp_lat);
      wait_idle(idx);
   endtask

   // tx_valid held high across two words; the second must follow the first's stop bit(s) directly.
   task automatic send_b2b(input int idx, input logic [7:0] d1, input logic [11:0] b1,
                           input logic [7:0] d2, input logic [11:0] b2, input int n);
      tick_sample();
      wait_ready(idx);
      data_r[idx]  = d1;
      valid_r[idx] = 1'b1;
      exp_q[idx].push_back('{bits: b1, n: 4'(n), b2b: 1'b0});
      tick_sample();
      data_r[idx]  = d2;
      exp_q[idx].push_back('{bits: b2, n: 4'(n), b2b: 1'b1});
      wait_ready(idx);
      tick_sample();
      valid_r[idx] = 1'b0;
      wait_idle(idx);
   endtask

   initial begin
      int bad [4];
      int t;

      vecs = '{
         '{0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10},
         '{1, 8'h07, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11},
         '{2, 8'h07, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11},
         '{3, 8'hFF, {1'b0, 2'b11, 8'hFF, 1'b0}, 11},
         '{1, 8'h00, {1'b0, 1'b1, 1'b0, 8'h00, 1'b0}, 11},
         '{2, 8'h00, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11},
         '{1, 8'hFF, {1'b0, 1'b1, 1'b0, 8'hFF, 1'b0}, 11},
         '{2, 8'h80, {1'b0, 1'b1, 1'b0, 8'h80, 1'b0}, 11},
         '{1, 8'h13, {1'b0, 1'b1, 1'b1, 8'h13, 1'b0}, 11},
         '{0, 8'h01, {2'b00, 1'b1, 8'h01, 1'b0}, 10},
         '{3, 8'h81, {1'b0, 2'b11, 8'h81, 1'b0}, 11}
      };

      // Reset state while reset is held.
      tick_sample();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst_tx_i%0d", i), int'(tx_w[i]), 1);
         chk($sformatf("rst_ready_i%0d", i), int'(ready_w[i]), 1);
         chk($sformatf("rst_busy_i%0d", i), int'(busy_w[i]), 0);
      end
      repeat (3) tick_sample();
      #1 reset = 1'b0;

      // Idle for 50 clk: line high, ready high, not busy.
      bad = '{default: 0};
      for (int c = 0; c < 50; c++) begin
         tick_sample();
         for (int i = 0; i < 4; i++) begin
            if (tx_w[i] !== 1'b1 || ready_w[i] !== 1'b1 || busy_w[i] !== 1'b0) bad[i]++;
         end
      end
      for (int i = 0; i < 4; i++) chk($sformatf("idle50_i%0d", i), bad[i], 0);

      // Table of single frames.
      for (int v = 0; v < 11; v++) begin
         send(int'(vecs[v].idx), vecs[v].data, vecs[v].bits, int'(vecs[v].n));
         wait_idle(int'(vecs[v].idx));
      end

      // Transfer coinciding with a tick waits a full interval; transfer just before a tick gives 2 clk.
      send_phase(0, 8'h5A, {2'b00, 1'b1, 8'h5A, 1'b0}, 10, 0, 7);
      send_phase(0, 8'h5A, {2'b00, 1'b1, 8'h5A, 1'b0}, 10, 5, 2);

      // Back-to-back frames with tx_valid held high.
      send_b2b(0, 8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0}, 8'hC3, {2'b00, 1'b1, 8'hC3, 1'b0}, 10);
      send_b2b(3, 8'hFF, {1'b0, 2'b11, 8'hFF, 1'b0}, 8'h00, {1'b0, 2'b11, 8'h00, 1'b0}, 11);

      // tx_valid pulses while busy must be ignored.
      send(0, 8'h96, {2'b00, 1'b1, 8'h96, 1'b0}, 10);
      for (int p = 0; p < 3; p++) begin
         repeat (8) tick_sample();
         chk($sformatf("pulse_ready_%0d", p), int'(ready_w[0]), 0);
         data_r[0]  = 8'h00;
         valid_r[0] = 1'b1;
         tick_sample();
         valid_r[0] = 1'b0;
      end
      wait_idle(0);
      repeat (20) tick_sample();
      chk("no_extra_frame", int'(busy_w[0]), 0);

      // Reset in the middle of data bit 3 abandons the frame at once.
      send(0, 8'hF0, {2'b00, 1'b1, 8'hF0, 1'b0}, 10);
      t = 0;
      while (cur_bit[0] != 4 && t < 200) begin
         tick_sample();
         t++;
      end
      chk("reach_data_bit3", cur_bit[0], 4);
      repeat (2) tick_sample();
      #1 reset = 1'b1;
      #1;
      chk("midrst_tx", int'(tx_w[0]), 1);
      chk("midrst_busy", int'(busy_w[0]), 0);
      chk("midrst_ready", int'(ready_w[0]), 1);
      repeat (3) tick_sample();
      #1 reset = 1'b0;
      send(0, 8'h55, {2'b00, 1'b1, 8'h55, 1'b0}, 10);
      wait_idle(0);

      repeat (10) tick_sample();
      for (int i = 0; i < 4; i++) chk($sformatf("queue_empty_i%0d", i), exp_q[i].size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion (errors=%0d checks=%0d)", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
